matrix_mem_responder: RTL and testbench

Word-addressed memory responder that services the `start_memory_transaction` / `done_memory_transaction` handshake driven by `matrix_mult_top`. It holds the operand and result matrices as 32-bit words and answers each load or store after a programmable latency. A host backdoor port preloads operands and reads back results without using the handshake. It sits between the multiplier top and the testbench or system memory model.

---
 rtl/matrix_mem_responder_if.sv | 30 +++
 rtl/matrix_mem_responder.sv | 100 ++++++++++
 tb/tb_matrix_mem_responder.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/matrix_mem_responder_if.sv
// Load/store handshake between an initiator (matrix_mult_top) and the memory responder.
interface matrix_mem_responder_if;
    logic        start_memory_transaction;
    logic [31:0] address_in;
    logic        write_enable;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        done_memory_transaction;
    logic        addr_error;

    modport master (
        output start_memory_transaction,
        output address_in,
        output write_enable,
        output write_data,
        input  read_data,
        input  done_memory_transaction,
        input  addr_error
    );

    modport slave (
        input  start_memory_transaction,
        input  address_in,
        input  write_enable,
        input  write_data,
        output read_data,
        output done_memory_transaction,
        output addr_error
    );
endinterface

// File: rtl/matrix_mem_responder.sv
// Word-addressed memory that answers load/store handshakes after a fixed latency,
// with a host backdoor port for preloading operands and reading back results.
module matrix_mem_responder #(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    matrix_mem_responder_if.slave    bus,
    input  logic                     host_we,
    input  logic [$clog2(DEPTH)-1:0] host_addr,
    input  logic [31:0]              host_wdata,
    output logic [31:0]              host_rdata
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(LATENCY) + 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state;
    state_t        state_next;
    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] idx_q;
    logic [AW-1:0] idx_sel;
    logic          we_q;
    logic          range_q;
    logic          we_sel;
    logic          range_sel;
    logic          range_in;
    logic          accept;
    logic          bus_wr;
    logic [CW-1:0] cnt;
    logic [29:0]   word_in;
    logic [31:0]   read_data_q;
    logic          done_q;
    logic          err_q;
    logic          unused;

    // Byte-lane bits carry no meaning for a word-only memory.
    assign unused    = ^bus.address_in[1:0];
    assign word_in   = bus.address_in[31:2];
    assign range_in  = {2'b00, word_in} < 32'(DEPTH);
    assign accept    = (state == IDLE) && bus.start_memory_transaction;
    assign idx_sel   = (state == IDLE) ? word_in[AW-1:0] : idx_q;
    assign range_sel = (state == IDLE) ? range_in : range_q;
    assign we_sel    = (state == IDLE) ? bus.write_enable : we_q;
    assign bus_wr    = (state == RESP) && we_q && range_q && !rst;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start_memory_transaction) state_next = (LATENCY == 1) ? RESP : WAIT;
            WAIT:    if (cnt == CW'(1)) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs are registered on entry to RESP so they are stable for the whole done cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            read_data_q <= '0;
        end else begin
            state  <= state_next;
            done_q <= (state_next == RESP);
            err_q  <= (state_next == RESP) && !range_sel;
            if ((state_next == RESP) && !we_sel)
                read_data_q <= range_sel ? mem[idx_sel] : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            idx_q   <= word_in[AW-1:0];
            we_q    <= bus.write_enable;
            range_q <= range_in;
            cnt     <= CW'(LATENCY - 1);
        end else if (state == WAIT) begin
            cnt <= cnt - CW'(1);
        end
    end

    // Bus store is written last so it wins a same-word collision with the host.
    always_ff @(posedge clk) begin
        if (host_we) mem[host_addr] <= host_wdata;
        if (bus_wr)  mem[idx_q]     <= bus.write_data;
    end

    always_ff @(posedge clk) begin
        if (rst) host_rdata <= '0;
        else     host_rdata <= mem[host_addr];
    end

    assign bus.read_data               = read_data_q;
    assign bus.done_memory_transaction = done_q;
    assign bus.addr_error              = err_q;
endmodule

// File: tb/tb_matrix_mem_responder.sv
// Directed and randomized checks of matrix_mem_responder at LATENCY 2 and 4
// against an array-based memory model.
module tb_matrix_mem_responder;
    localparam int DEPTH = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst2, rst4, sel, start, we, h_we;
    logic [31:0] addr, wdata, h_wdata, hr2, hr4;
    logic [5:0]  h_addr;
    logic        done_mux, err_mux;
    logic [31:0] rd_mux, hr_mux;
    logic [31:0] model [2][DEPTH];
    logic [31:0] exp_rd [2];
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;

    matrix_mem_responder_if b2 ();
    matrix_mem_responder_if b4 ();

    // sel steers the shared stimulus to one responder; the other sees start low.
    assign b2.start_memory_transaction = start & ~sel;
    assign b4.start_memory_transaction = start & sel;
    assign b2.address_in   = addr;
    assign b4.address_in   = addr;
    assign b2.write_enable = we;
    assign b4.write_enable = we;
    assign b2.write_data   = wdata;
    assign b4.write_data   = wdata;
    assign done_mux = sel ? b4.done_memory_transaction : b2.done_memory_transaction;
    assign err_mux  = sel ? b4.addr_error : b2.addr_error;
    assign rd_mux   = sel ? b4.read_data : b2.read_data;
    assign hr_mux   = sel ? hr4 : hr2;

    matrix_mem_responder #(.DEPTH(DEPTH), .LATENCY(2)) dut2 (
        .clk(clk), .rst(rst2), .bus(b2), .host_we(h_we & ~sel),
        .host_addr(h_addr), .host_wdata(h_wdata), .host_rdata(hr2)
    );

    matrix_mem_responder #(.DEPTH(DEPTH), .LATENCY(4)) dut4 (
        .clk(clk), .rst(rst4), .bus(b4), .host_we(h_we & sel),
        .host_addr(h_addr), .host_wdata(h_wdata), .host_rdata(hr4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic int lat();
        return sel ? 4 : 2;
    endfunction

    task automatic host_wr(input logic [5:0] a, input logic [31:0] d);
        h_we = 1'b1; h_addr = a; h_wdata = d;
        tick();
        h_we = 1'b0;
        model[sel][a] = d;
    endtask

    task automatic host_rd(input string tag, input logic [5:0] a);
        h_addr = a;
        tick();
        check(tag, hr_mux, model[sel][a]);
    endtask

    // One complete transfer; store data only appears in the done cycle, and an
    // optional host write lands on the same edge as the bus store.
    task automatic bus_xfer(input logic [31:0] a, input bit w, input logic [31:0] d,
                            input bit hw, input logic [5:0] ha, input logic [31:0] hd);
        int n;
        bit got;
        bit inr;
        logic [5:0] idx;
        inr = a < 32'(DEPTH * 4);
        idx = a[7:2];
        start = 1'b1; addr = a; we = w; wdata = ~d;
        n = 0; got = 1'b0;
        while (!got && n < 20) begin
            tick();
            n++;
            got = done_mux;
        end
        check("done_seen", 32'(got), 1);
        if (got) begin
            check("latency", n, lat());
            if (!w) exp_rd[sel] = inr ? model[sel][idx] : 32'h0;
            check("read_data", rd_mux, exp_rd[sel]);
            check("addr_error", 32'(err_mux), 32'(!inr));
        end
        wdata = d; start = 1'b0;
        if (hw) begin
            h_we = 1'b1; h_addr = ha; h_wdata = hd;
            model[sel][ha] = hd;
        end
        if (w && inr) model[sel][idx] = d;
        tick();
        h_we = 1'b0;
        check("done_pulse", 32'(done_mux), 0);
        check("err_pulse", 32'(err_mux), 0);
    endtask

    initial begin
        int ndone, last, n, r;
        bit w;
        logic [31:0] a;

        sel = 1'b0; start = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        h_we = 1'b0; h_addr = '0; h_wdata = '0; rst2 = 1'b1; rst4 = 1'b1;
        exp_rd[0] = '0; exp_rd[1] = '0;
        repeat (3) tick();
        check("rst_done2", 32'(b2.done_memory_transaction), 0);
        check("rst_err2", 32'(b2.addr_error), 0);
        check("rst_rd2", b2.read_data, 0);
        check("rst_hrd2", hr2, 0);
        check("rst_done4", 32'(b4.done_memory_transaction), 0);
        check("rst_rd4", b4.read_data, 0);
        check("rst_hrd4", hr4, 0);
        rst2 = 1'b0; rst4 = 1'b0;
        tick();

        for (int i = 0; i < DEPTH; i++) host_wr(6'(i), $urandom);

        host_wr(6'd3, 32'h0000_1234);
        bus_xfer(32'h0000_000C, 1'b0, 32'h0, 1'b0, 6'd0, 32'h0);

        bus_xfer(32'h0000_0010, 1'b1, 32'hDEAD_BEEF, 1'b0, 6'd0, 32'h0);
        host_rd("store_backdoor", 6'd4);

        // Streaming loads with start held high the whole time.
        start = 1'b1; addr = 32'h0; we = 1'b0; ndone = 0; last = 0;
        for (int k = 0; k < 18 * 3 + 10 && ndone < 18; k++) begin
            tick();
            if (done_mux) begin
                check("stream_rd", rd_mux, model[0][ndone[5:0]]);
                if (ndone > 0) check("stream_gap", cyc - last, 3);
                last = cyc;
                ndone++;
                addr = 32'(ndone * 4);
            end
        end
        start = 1'b0;
        repeat (6) begin
            tick();
            if (done_mux) ndone++;
        end
        check("stream_count", ndone, 18);
        exp_rd[0] = model[0][17];

        bus_xfer(32'h0000_0100, 1'b0, 32'h0, 1'b0, 6'd0, 32'h0);
        bus_xfer(32'h0000_0100, 1'b1, 32'hA5A5_5A5A, 1'b0, 6'd0, 32'h0);
        bus_xfer(32'h8000_000C, 1'b1, 32'h1357_9BDF, 1'b0, 6'd0, 32'h0);
        for (int i = 0; i < DEPTH; i++) host_rd("oor_scan", 6'(i));

        bus_xfer(32'h0000_0014, 1'b1, 32'h1, 1'b1, 6'd5, 32'h2);
        host_rd("collision", 6'd5);

        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 7);
            a = 32'($urandom_range(0, 255));
            if (r == 0) a = a | (32'h1 << $urandom_range(8, 31));
            w = 1'($urandom_range(0, 1));
            bus_xfer(a, w, $urandom, ($urandom_range(0, 3) == 0), 6'($urandom), $urandom);
            host_rd("rand_backdoor", a[7:2]);
        end

        // Reset in the middle of a LATENCY=4 store.
        sel = 1'b1;
        host_wr(6'd9, 32'hC0FF_EE09);
        bus_xfer(32'h0000_0024, 1'b0, 32'h0, 1'b0, 6'd0, 32'h0);
        start = 1'b1; addr = 32'h0000_0024; we = 1'b1; wdata = 32'h0BAD_F00D;
        tick();
        tick();
        rst4 = 1'b1; start = 1'b0;
        tick();
        check("rst_mid_done", 32'(done_mux), 0);
        check("rst_mid_rd", rd_mux, 0);
        rst4 = 1'b0;
        exp_rd[1] = '0;
        n = 0;
        repeat (8) begin
            tick();
            if (done_mux) n++;
        end
        check("rst_no_done", n, 0);
        host_rd("rst_word_kept", 6'd9);
        bus_xfer(32'h0000_0024, 1'b0, 32'h0, 1'b0, 6'd0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
